// File: rtl/demux_1to32_capture.sv
// demux_1to32_capture: steers a serial bit stream or direct single-bit writes into a register published on frame completion
module demux_1to32_capture #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              din,
  input  logic              din_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_bit,
  output logic              busy,
  output logic [ADDR_W-1:0] idx,
  output logic [WIDTH-1:0]  dout,
  output logic              frame_done,
  output logic              overrun
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;
  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d, dout_q, dout_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d, ovr_q, ovr_d;
  logic              last;
  assign last = idx_q == ADDR_W'(WIDTH - 1);
  // start has priority in both states; direct writes only land when idle
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    if (start) begin
      state_d  = FILL;
      shadow_d = '0;
      idx_d    = '0;
    end else if (state_q == FILL) begin
      if (din_valid) begin
        shadow_d[idx_q] = din;
        idx_d           = idx_q + 1'b1;
        if (last) begin
          dout_d  = {din, shadow_q[WIDTH-2:0]};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    end else begin
      if (wr_en) begin
        shadow_d[wr_addr] = wr_bit;
        dout_d[wr_addr]   = wr_bit;
      end
      if (din_valid) ovr_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      dout_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end
  assign busy       = state_q == FILL;
  assign idx        = idx_q;
  assign dout       = dout_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_demux_1to32_capture.sv
// tb_demux_1to32_capture: directed checks of frame fill, direct writes, restart, reset and overrun
module tb_demux_1to32_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic        wr_bit = 1'b0;
  logic        busy;
  logic [4:0]  idx;
  logic [31:0] dout;
  logic        frame_done;
  logic        overrun;
  int          n_chk = 0;
  int          n_err = 0;
  int          pulses;
  demux_1to32_capture dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bit(wr_bit), .busy(busy), .idx(idx),
    .dout(dout), .frame_done(frame_done), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic send_bits(input logic [31:0] data, input int n, input bit gaps, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      din       = data[i];
      din_valid = 1'b1;
      step();
      seen += int'(frame_done);
      din_valid = 1'b0;
      if (gaps && i != n - 1) begin
        repeat ($urandom_range(1, 3)) begin
          step();
          seen += int'(frame_done);
        end
      end
    end
  endtask
  task automatic check_frame(input string tag, input logic [31:0] exp, input int seen);
    chk({tag, "_done"}, {31'b0, frame_done}, 32'd1);
    chk({tag, "_dout"}, dout, exp);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_idx"}, {27'b0, idx}, 32'd0);
    chk({tag, "_pulses"}, seen, 32'd1);
    step();
    chk({tag, "_done_drop"}, {31'b0, frame_done}, 32'd0);
  endtask
  initial begin
    for (int c = 0; c < 2; c++) begin
      {start, din, din_valid, wr_en, wr_bit} = 5'($urandom);
      wr_addr = 5'($urandom);
      step();
    end
    chk("rst_dout", dout, 32'd0);
    chk("rst_idx", {27'b0, idx}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, frame_done}, 32'd0);
    chk("rst_ovr", {31'b0, overrun}, 32'd0);
    rst = 1'b0;
    {start, din, din_valid, wr_en, wr_bit} = '0;
    wr_addr = '0;
    step();
    pulse_start();
    chk("s2_busy", {31'b0, busy}, 32'd1);
    send_bits(32'hA5C3_0F96, 31, 1'b0, pulses);
    chk("s2_mid_dout", dout, 32'd0);
    chk("s2_mid_idx", {27'b0, idx}, 32'd31);
    chk("s2_mid_done", {31'b0, frame_done}, 32'd0);
    din = 1'b1;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check_frame("s2", 32'hA5C3_0F96, 1);
    pulse_start();
    send_bits(32'hA5C3_0F96, 32, 1'b1, pulses);
    check_frame("s3", 32'hA5C3_0F96, pulses);
    wr_en = 1'b1;
    wr_addr = 5'd31;
    wr_bit = 1'b0;
    step();
    wr_en = 1'b0;
    chk("s4_wr_dout", dout, 32'h25C3_0F96);
    chk("s4_wr_done", {31'b0, frame_done}, 32'd0);
    chk("s4_wr_busy", {31'b0, busy}, 32'd0);
    pulse_start();
    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_bit = 1'b1;
    step();
    wr_en = 1'b0;
    chk("s4_fill_wr", dout, 32'h25C3_0F96);
    chk("s4_fill_idx", {27'b0, idx}, 32'd0);
    send_bits(32'hFFFF_FFFF, 10, 1'b0, pulses);
    chk("s5_idx10", {27'b0, idx}, 32'd10);
    pulse_start();
    chk("s5_re_idx", {27'b0, idx}, 32'd0);
    chk("s5_re_busy", {31'b0, busy}, 32'd1);
    chk("s5_re_done", {31'b0, frame_done}, 32'd0);
    send_bits(32'h1234_5678, 32, 1'b0, pulses);
    check_frame("s5_re", 32'h1234_5678, pulses);
    pulse_start();
    send_bits(32'hFFFF_FFFF, 10, 1'b0, pulses);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_rst_dout", dout, 32'd0);
    chk("s5_rst_busy", {31'b0, busy}, 32'd0);
    chk("s5_rst_idx", {27'b0, idx}, 32'd0);
    din = 1'b1;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("s6_ovr", {31'b0, overrun}, 32'd1);
    chk("s6_ovr_dout", dout, 32'd0);
    chk("s6_ovr_idx", {27'b0, idx}, 32'd0);
    start = 1'b1;
    wr_en = 1'b1;
    wr_addr = 5'd3;
    wr_bit = 1'b1;
    din_valid = 1'b1;
    step();
    {start, wr_en, din_valid} = '0;
    chk("s6_sw_busy", {31'b0, busy}, 32'd1);
    chk("s6_sw_dout", dout, 32'd0);
    chk("s6_sw_idx", {27'b0, idx}, 32'd0);
    send_bits(32'hDEAD_BEEF, 32, 1'b1, pulses);
    check_frame("s6", 32'hDEAD_BEEF, pulses);
    chk("s6_ovr_sticky", {31'b0, overrun}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
